// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM encoding for the SPI mode-0 target
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  localparam logic [7:0] SPI_IDLE_FILL = 8'hFF;
  localparam int SPI_MIN_CLK_RATIO = 8;
  typedef enum logic {ST_IDLE, ST_SHIFT} spi_state_e;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins plus the internal rx/tx word handshake
interface spi_target_if import spi_pkg::*; #(parameter int WIDTH = SPI_WIDTH);
  logic spi_sck;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  logic [WIDTH-1:0] rx_data;
  logic rx_valid;
  logic [WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic busy;
  logic underrun;
  modport slave (
    input spi_sck, spi_ss_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, underrun
  );
  modport master (
    output spi_sck, spi_ss_n, spi_mosi, tx_data, tx_valid,
    input spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, underrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with one extra flop for rise/fall pulses
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_level = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/spi_target.sv
// spi_target: oversampled SPI mode-0 responder with a one-entry tx holding buffer
module spi_target import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_FILL = WIDTH'(SPI_IDLE_FILL)
) (
  input logic clk,
  input logic rst,
  spi_target_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall, w_mosi;
  logic w_last, w_load, w_capture;
  logic [WIDTH-1:0] w_load_word;
  spi_state_e r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift, r_tx_shift, r_buf, r_rx_data;
  logic r_tx_ready, r_miso, r_oe, r_busy, r_rx_valid, r_underrun;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk, .rst, .i_d(bus.spi_sck), .o_level(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk, .rst, .i_d(bus.spi_ss_n), .o_level(), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk, .rst, .i_d(bus.spi_mosi), .o_level(w_mosi), .o_rise(), .o_fall()
  );
  // Loads happen at select and on the first falling sck after a completed word
  always_comb begin
    w_last = r_bit_cnt == CW'(WIDTH - 1);
    w_load = (r_state == ST_IDLE) ? w_ss_fall : (!w_ss_rise && w_sck_fall && r_bit_cnt == '0);
    w_load_word = r_tx_ready ? IDLE_FILL : r_buf;
    w_capture = bus.tx_valid && r_tx_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_bit_cnt <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_buf <= '0;
      r_rx_data <= '0;
      r_tx_ready <= 1'b1;
      r_miso <= 1'b0;
      r_oe <= 1'b0;
      r_busy <= 1'b0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= w_load && r_tx_ready;
      r_tx_ready <= w_capture ? 1'b0 : (w_load ? 1'b1 : r_tx_ready);
      if (w_capture) r_buf <= bus.tx_data;
      if (w_load) begin
        r_tx_shift <= w_load_word;
        r_miso <= w_load_word[WIDTH-1];
      end
      if (r_state == ST_IDLE) begin
        if (w_ss_fall) begin
          r_state <= ST_SHIFT;
          r_bit_cnt <= '0;
          r_busy <= 1'b1;
          r_oe <= 1'b1;
        end
      end else if (w_ss_rise) begin
        r_state <= ST_IDLE;
        r_bit_cnt <= '0;
        r_busy <= 1'b0;
        r_oe <= 1'b0;
        r_miso <= 1'b0;
      end else if (w_sck_rise) begin
        r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        if (w_last) begin
          r_rx_data <= {r_rx_shift[WIDTH-2:0], w_mosi};
          r_rx_valid <= 1'b1;
        end
      end else if (w_sck_fall && r_bit_cnt != '0) begin
        r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
        r_miso <= r_tx_shift[WIDTH-2];
      end
    end
  assign bus.spi_miso = r_miso;
  assign bus.spi_miso_oe = r_oe;
  assign bus.rx_data = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_ready = r_tx_ready;
  assign bus.busy = r_busy;
  assign bus.underrun = r_underrun;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed scenarios for spi_target with an SCK of clk/8
module tb_spi_target;
  import spi_pkg::*;
  localparam int HALF = SPI_MIN_CLK_RATIO / 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0;
  int und_cnt = 0;
  int und_rise = 0;
  int n_rises = 0;
  logic [7:0] rx_log [8];
  logic [7:0] miso_got [2];
  spi_target_if #(.WIDTH(8)) bus();
  spi_target #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt % 8] = bus.rx_data;
      rx_cnt++;
    end
    if (bus.underrun) begin
      und_cnt++;
      und_rise = n_rises;
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic preload(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
    wait_clk(1);
  endtask
  // n words; SS is released together with the final (or stop_after-th) sck fall
  task automatic spi_xfer(input int n, input logic [7:0] d0, input logic [7:0] d1, input int stop_after);
    logic [7:0] d;
    int r;
    r = 0;
    bus.spi_ss_n = 1'b0;
    for (int w = 0; w < n; w++) begin
      d = (w == 0) ? d0 : d1;
      for (int b = 7; b >= 0; b--) begin
        bus.spi_mosi = d[b];
        wait_clk(HALF);
        miso_got[w][b] = bus.spi_miso;
        bus.spi_sck = 1'b1;
        r++;
        n_rises++;
        wait_clk(HALF);
        bus.spi_sck = 1'b0;
        if ((stop_after != 0 && r == stop_after) || (w == n - 1 && b == 0)) begin
          bus.spi_ss_n = 1'b1;
          wait_clk(8);
          return;
        end
      end
    end
  endtask
  task automatic test_reset;
    wait_clk(3);
    n_cmp++; if (bus.spi_miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", bus.spi_miso); end
    n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", bus.spi_miso_oe); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
    rst = 1'b0;
    wait_clk(4);
  endtask
  task automatic test_single_word;
    int rb, ub;
    preload(8'h3C);
    n_cmp++; if (bus.tx_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_low: got %b want 0", bus.tx_ready); end
    rb = rx_cnt; ub = und_cnt;
    spi_xfer(1, 8'hA5, 8'h00, 0);
    n_cmp++; if (rx_cnt - rb !== 1) begin n_bad++; $display("FAIL single_rx_pulses: got %0d want 1", rx_cnt - rb); end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_rx_data: got %h want a5", bus.rx_data); end
    n_cmp++; if (miso_got[0] !== 8'h3C) begin n_bad++; $display("FAIL single_miso: got %h want 3c", miso_got[0]); end
    n_cmp++; if (und_cnt - ub !== 0) begin n_bad++; $display("FAIL single_underrun: got %0d want 0", und_cnt - ub); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL single_oe_end: got %b want 0", bus.spi_miso_oe); end
  endtask
  task automatic test_back_to_back;
    int rb, ub, nb;
    preload(8'h3C);
    rb = rx_cnt; ub = und_cnt; nb = n_rises;
    spi_xfer(2, 8'h5A, 8'hC3, 0);
    n_cmp++; if (rx_cnt - rb !== 2) begin n_bad++; $display("FAIL b2b_rx_pulses: got %0d want 2", rx_cnt - rb); end
    n_cmp++; if (rx_log[rb % 8] !== 8'h5A) begin n_bad++; $display("FAIL b2b_rx0: got %h want 5a", rx_log[rb % 8]); end
    n_cmp++; if (rx_log[(rb + 1) % 8] !== 8'hC3) begin n_bad++; $display("FAIL b2b_rx1: got %h want c3", rx_log[(rb + 1) % 8]); end
    n_cmp++; if (miso_got[0] !== 8'h3C) begin n_bad++; $display("FAIL b2b_miso0: got %h want 3c", miso_got[0]); end
    n_cmp++; if (miso_got[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_miso1: got %h want ff", miso_got[1]); end
    n_cmp++; if (und_cnt - ub !== 1) begin n_bad++; $display("FAIL b2b_underrun_cnt: got %0d want 1", und_cnt - ub); end
    n_cmp++; if (und_rise - nb !== 8) begin n_bad++; $display("FAIL b2b_underrun_at: got %0d want 8", und_rise - nb); end
  endtask
  task automatic test_abort;
    int rb;
    rb = rx_cnt;
    spi_xfer(1, 8'hF0, 8'h00, 5);
    n_cmp++; if (rx_cnt - rb !== 0) begin n_bad++; $display("FAIL abort_rx_pulses: got %0d want 0", rx_cnt - rb); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    spi_xfer(1, 8'h0F, 8'h00, 0);
    n_cmp++; if (rx_cnt - rb !== 1) begin n_bad++; $display("FAIL abort_next_pulses: got %0d want 1", rx_cnt - rb); end
    n_cmp++; if (bus.rx_data !== 8'h0F) begin n_bad++; $display("FAIL abort_next_data: got %h want 0f", bus.rx_data); end
    n_cmp++; if (miso_got[0] !== 8'hFF) begin n_bad++; $display("FAIL abort_next_miso: got %h want ff", miso_got[0]); end
  endtask
  task automatic test_handshake;
    int ub;
    bit seen;
    ub = und_cnt;
    bus.tx_data = 8'h11;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    n_cmp++; if (bus.tx_ready !== 1'b0) begin n_bad++; $display("FAIL hs_ready_drop: got %b want 0", bus.tx_ready); end
    bus.tx_data = 8'h22;
    wait_clk(3);
    n_cmp++; if (bus.tx_ready !== 1'b0) begin n_bad++; $display("FAIL hs_ready_full: got %b want 0", bus.tx_ready); end
    seen = 1'b0;
    fork
      spi_xfer(2, 8'h00, 8'h00, 0);
      begin
        for (int i = 0; i < 60 && !seen; i++) begin
          wait_clk(1);
          seen = bus.tx_ready;
        end
        wait_clk(1);
        bus.tx_valid = 1'b0;
      end
    join
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL hs_ready_rise: got %b want 1", seen); end
    n_cmp++; if (miso_got[0] !== 8'h11) begin n_bad++; $display("FAIL hs_miso0: got %h want 11", miso_got[0]); end
    n_cmp++; if (miso_got[1] !== 8'h22) begin n_bad++; $display("FAIL hs_miso1: got %h want 22", miso_got[1]); end
    n_cmp++; if (und_cnt - ub !== 0) begin n_bad++; $display("FAIL hs_underrun: got %0d want 0", und_cnt - ub); end
    n_cmp++; if (bus.tx_ready !== 1'b1) begin n_bad++; $display("FAIL hs_ready_end: got %b want 1", bus.tx_ready); end
  endtask
  task automatic test_reset_mid_word;
    int rb;
    rb = rx_cnt;
    bus.spi_ss_n = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.spi_mosi = b[0];
      wait_clk(HALF);
      bus.spi_sck = 1'b1;
      wait_clk(HALF);
      bus.spi_sck = 1'b0;
    end
    preload(8'h77);
    n_cmp++; if (bus.spi_miso_oe !== 1'b1) begin n_bad++; $display("FAIL rmw_oe_active: got %b want 1", bus.spi_miso_oe); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL rmw_oe_reset: got %b want 0", bus.spi_miso_oe); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmw_busy_reset: got %b want 0", bus.busy); end
    n_cmp++; if (bus.tx_ready !== 1'b1) begin n_bad++; $display("FAIL rmw_ready_reset: got %b want 1", bus.tx_ready); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL rmw_rx_data_reset: got %h want 00", bus.rx_data); end
    bus.spi_ss_n = 1'b1;
    bus.spi_sck = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(6);
    n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL rmw_oe_after: got %b want 0", bus.spi_miso_oe); end
    n_cmp++; if (rx_cnt - rb !== 0) begin n_bad++; $display("FAIL rmw_rx_pulses: got %0d want 0", rx_cnt - rb); end
    spi_xfer(1, 8'h96, 8'h00, 0);
    n_cmp++; if (rx_cnt - rb !== 1) begin n_bad++; $display("FAIL rmw_next_pulses: got %0d want 1", rx_cnt - rb); end
    n_cmp++; if (bus.rx_data !== 8'h96) begin n_bad++; $display("FAIL rmw_next_data: got %h want 96", bus.rx_data); end
    n_cmp++; if (miso_got[0] !== 8'hFF) begin n_bad++; $display("FAIL rmw_next_miso: got %h want ff", miso_got[0]); end
  endtask
  initial begin
    bus.spi_sck = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset;
    test_single_word;
    test_back_to_back;
    test_abort;
    test_handshake;
    test_reset_mid_word;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0) for the iCE40 fabric; the far end of the SPI initiator that drives SS/SCK/MOSI from a divided HFOSC clock.
- Oversamples the external SCK/SS/MOSI in the system clock domain and deserialises MOSI into bytes, MSB first.
- Serialises a response byte onto MISO from a one-entry transmit holding buffer.
- Sits between the board SPI pins and internal logic (loopback, command decoder, LED control).

Parameters:
WIDTH, 8, bits per SPI word
SYNC_STAGES, 2, synchroniser flops per input pin (>=2)
IDLE_FILL, 8'hFF, word shifted out when the transmit buffer is empty (width WIDTH)

Ports:
clk  input  1  system clock (HFOSC or derived); all logic on posedge clk
rst  input  1  asynchronous, active-high reset
spi_sck  input  1  external SPI clock, asynchronous to clk
spi_ss_n  input  1  external chip select, active low, asynchronous
spi_mosi  input  1  external data in, asynchronous
spi_miso  output  1  data out to the initiator
spi_miso_oe  output  1  tristate enable for the MISO pad, high while selected
rx_data  output  WIDTH  last complete received word
rx_valid  output  1  one-clk pulse when rx_data updates
tx_data  input  WIDTH  response word
tx_valid  input  1  tx_data offered
tx_ready  output  1  holding buffer empty; transfer occurs when tx_valid && tx_ready
busy  output  1  synchronised select active
underrun  output  1  one-clk pulse when IDLE_FILL is loaded because the buffer was empty

Behaviour:
- Reset values (async, rst high):
  - spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, underrun=0.
  - Synchroniser chains: ss=1, sck=0, mosi=0.
  - Bit counter=0, state=IDLE, holding buffer empty.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops.
  - One more flop per signal provides the edge detect for sck and ss.
  - mosi is delayed to align with the sck edge detect.
  - Requirement: f_sck <= f_clk/8. At 48 MHz clk this means SCK <= 6 MHz.
- FSM states:
  - IDLE -> SHIFT on a synchronised ss falling edge. Actions: bit_cnt<=0; load shifter; busy=1; spi_miso_oe=1.
  - SHIFT -> IDLE on a synchronised ss rising edge. Actions: discard any partial word (no rx_valid); bit_cnt<=0; busy=0; spi_miso_oe=0; spi_miso=0.
  - A SHIFT->IDLE abort takes priority over an sck edge in the same cycle.
- Receive (SHIFT state, sck rising edge):
  - rx_shift <= {rx_shift[WIDTH-2:0], mosi}; bit_cnt increments.
  - When bit_cnt reaches WIDTH-1 on this edge: rx_data <= completed word and rx_valid=1 for exactly one clk, latency 1 clk after the edge is detected.
  - bit_cnt then wraps to 0.
  - No rx backpressure; consumers must sample on rx_valid.
- Transmit:
  - spi_miso = tx_shift MSB while in SHIFT.
  - On sck falling edge in SHIFT: tx_shift shifts left by 1.
  - If that falling edge follows the last bit of a word (bit_cnt==0 after wrap), tx_shift is reloaded instead of shifted.
  - Load rule, applied at every load (ss assert and word boundary):
    - Buffer full: load it, mark it empty (tx_ready rises the next cycle).
    - Buffer empty: load IDLE_FILL and pulse underrun for 1 clk.
  - A word loaded at a load point is consumed even if the transaction aborts mid-word.
- Holding buffer:
  - tx_valid && tx_ready captures tx_data; tx_ready falls the next cycle.
  - A capture in the same cycle as a load with an empty buffer: no bypass. The load takes IDLE_FILL; the captured word is kept for the next load.
- sck edges while in IDLE are ignored. MOSI changes without sck edges have no effect.
- Reset asserted mid-transfer: immediate return to reset values; any partial word and buffered tx word are lost.

Decomposition:
- Shared package spi_pkg holds:
  - Default WIDTH and IDLE_FILL constants.
  - FSM state encoding (IDLE, SHIFT).
  - A localparam for the minimum clk/sck ratio (8), for bench checks.
- One sub-module, spi_sync_edge:
  - Parameterised SYNC_STAGES synchroniser with rise/fall pulse outputs.
  - Reset value is a parameter (1 for ss, 0 for sck/mosi).
  - Instantiated for sck and ss; mosi uses it without the edge outputs.

Test Plan:
- Reset: assert rst mid-simulation -> all outputs at the listed reset values within the same cycle; tx_ready=1, busy=0.
- Single word: preload tx 0x3C, initiator sends 0xA5 at clk/8 ->
  - rx_data=0xA5 with a single rx_valid pulse.
  - MISO bits sampled at rising sck = 0,0,1,1,1,1,0,0.
  - underrun never pulses.
- Back-to-back words without releasing SS, only 0x3C preloaded ->
  - Second MISO word = 0xFF.
  - underrun pulses exactly once, at the word boundary.
  - Two rx_valid pulses.
- Abort: SS deasserted after 5 rising sck edges -> no rx_valid. The next full transaction sending 0x0F returns rx_data=0x0F.
- Holding-buffer handshake:
  - Write 0x11; tx_ready drops; offer 0x22 -> not accepted while full.
  - After the load, tx_ready=1; 0x22 is accepted and transmitted in the following word.
- Reset during word: rst pulsed after 3 bits -> no rx_valid. spi_miso_oe=0 until the next ss assertion; the subsequent transaction operates normally.
